// File: rtl/tcu_uop_sequencer_pkg.sv
// Shared TCU package: tile/step geometry, register bases, format IDs,
// micro-op record layout and the sequencer FSM state type.
package tcu_uop_sequencer_pkg;

  localparam int TCU_M_STEPS = 4;
  localparam int TCU_N_STEPS = 2;
  localparam int TCU_K_STEPS = 2;
  localparam int TCU_UOPS    = TCU_M_STEPS * TCU_N_STEPS * TCU_K_STEPS;

  localparam int TCU_RA      = 0;
  localparam int TCU_RB      = 28;
  localparam int TCU_RC      = 10;
  localparam int TCU_NR_BITS = 5;

  typedef enum logic [3:0] {
    TCU_FMT_FP32 = 4'd0,
    TCU_FMT_FP16 = 4'd1,
    TCU_FMT_BF16 = 4'd2,
    TCU_FMT_FP8  = 4'd3
  } tcu_fmt_e;

  // Step counter width; a single-step dimension still gets one bit.
  function automatic int step_w(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  localparam int TCU_SM_W = step_w(TCU_M_STEPS);
  localparam int TCU_SN_W = step_w(TCU_N_STEPS);
  localparam int TCU_SK_W = step_w(TCU_K_STEPS);

  typedef struct packed {
    logic [TCU_SM_W-1:0]    step_m;
    logic [TCU_SN_W-1:0]    step_n;
    logic [TCU_SK_W-1:0]    step_k;
    logic [TCU_NR_BITS-1:0] rs1;
    logic [TCU_NR_BITS-1:0] rs2;
    logic [TCU_NR_BITS-1:0] rs3;
    logic [TCU_NR_BITS-1:0] rd;
    logic                   first;
    logic                   last;
  } tcu_uop_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } tcu_seq_state_e;

endpackage

// File: rtl/tcu_uop_sequencer_if.sv
// Dispatch-slot / FEDP handshake bundle for the micro-op sequencer.
//   in_*  : one WMMA instruction from dispatch (valid/ready)
//   out_* : stream of micro-ops to the FEDP (valid/ready)
// master = dispatch + FEDP side, slave = sequencer.
interface tcu_uop_sequencer_if
  import tcu_uop_sequencer_pkg::*;
#(
  parameter int TAG_W   = 16,
  parameter int NR_BITS = TCU_NR_BITS,
  parameter int SM_W    = TCU_SM_W,
  parameter int SN_W    = TCU_SN_W,
  parameter int SK_W    = TCU_SK_W
);
  logic               in_valid;
  logic               in_ready;
  logic [TAG_W-1:0]   in_tag;
  logic [3:0]         in_fmt_s;
  logic [3:0]         in_fmt_d;
  logic               out_valid;
  logic               out_ready;
  logic [TAG_W-1:0]   out_tag;
  logic [3:0]         out_fmt_s;
  logic [3:0]         out_fmt_d;
  logic [SM_W-1:0]    out_step_m;
  logic [SN_W-1:0]    out_step_n;
  logic [SK_W-1:0]    out_step_k;
  logic [NR_BITS-1:0] out_rs1;
  logic [NR_BITS-1:0] out_rs2;
  logic [NR_BITS-1:0] out_rs3;
  logic [NR_BITS-1:0] out_rd;
  logic               out_first;
  logic               out_last;

  modport master (
    output in_valid, in_tag, in_fmt_s, in_fmt_d, out_ready,
    input  in_ready, out_valid, out_tag, out_fmt_s, out_fmt_d,
           out_step_m, out_step_n, out_step_k,
           out_rs1, out_rs2, out_rs3, out_rd, out_first, out_last
  );

  modport slave (
    input  in_valid, in_tag, in_fmt_s, in_fmt_d, out_ready,
    output in_ready, out_valid, out_tag, out_fmt_s, out_fmt_d,
           out_step_m, out_step_n, out_step_k,
           out_rs1, out_rs2, out_rs3, out_rd, out_first, out_last
  );
endinterface

// File: rtl/tcu_uop_sequencer.sv
// Expands one accepted WMMA instruction into M_STEPS*N_STEPS*K_STEPS
// micro-ops (n innermost, then m, k outermost) with resolved A/B/C
// register indices.
// Ports: clk, reset (sync, active-high), io (slave side of
// tcu_uop_sequencer_if: instruction in, micro-op stream out).
module tcu_uop_sequencer
  import tcu_uop_sequencer_pkg::*;
#(
  parameter int M_STEPS = TCU_M_STEPS,
  parameter int N_STEPS = TCU_N_STEPS,
  parameter int K_STEPS = TCU_K_STEPS,
  parameter int RA      = TCU_RA,
  parameter int RB      = TCU_RB,
  parameter int RC      = TCU_RC,
  parameter int NR_BITS = TCU_NR_BITS,
  parameter int TAG_W   = 16
) (
  input logic                 clk,
  input logic                 reset,
  tcu_uop_sequencer_if.slave  io
);
  localparam int SM_W = step_w(M_STEPS);
  localparam int SN_W = step_w(N_STEPS);
  localparam int SK_W = step_w(K_STEPS);

  tcu_seq_state_e     state_q, state_d;
  logic [SM_W-1:0]    m_q, m_d;
  logic [SN_W-1:0]    n_q, n_d;
  logic [SK_W-1:0]    k_q, k_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [3:0]         fmt_s_q, fmt_s_d;
  logic [3:0]         fmt_d_q, fmt_d_d;
  logic [NR_BITS-1:0] rs1_q, rs1_d;
  logic [NR_BITS-1:0] rs2_q, rs2_d;
  logic [NR_BITS-1:0] rd_q, rd_d;
  logic               first_q, first_d;
  logic               last_q, last_d;

  logic fire, accept, in_ready;
  logic n_wrap, m_wrap;

  always_comb begin
    fire     = (state_q == ST_BUSY) && io.out_ready;
    // Accepting on the last fire keeps back-to-back instructions bubble-free.
    in_ready = (state_q == ST_IDLE) || (fire && last_q);
    accept   = io.in_valid && in_ready;
    n_wrap   = (n_q == SN_W'(N_STEPS - 1));
    m_wrap   = (m_q == SM_W'(M_STEPS - 1));

    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    tag_d   = tag_q;
    fmt_s_d = fmt_s_q;
    fmt_d_d = fmt_d_q;

    if (accept) begin
      state_d = ST_BUSY;
      m_d     = '0;
      n_d     = '0;
      k_d     = '0;
      tag_d   = io.in_tag;
      fmt_s_d = io.in_fmt_s;
      fmt_d_d = io.in_fmt_d;
    end else if (fire) begin
      if (last_q) begin
        state_d = ST_IDLE;
        m_d     = '0;
        n_d     = '0;
        k_d     = '0;
      end else if (!n_wrap) begin
        n_d = n_q + SN_W'(1);
      end else begin
        n_d = '0;
        if (!m_wrap) begin
          m_d = m_q + SM_W'(1);
        end else begin
          m_d = '0;
          k_d = k_q + SK_W'(1);
        end
      end
    end

    // Register indices and first/last are registered from the next counter
    // values so every output comes straight from a flop and is zero in reset.
    rs1_d   = NR_BITS'(RA + int'(m_d) * K_STEPS + int'(k_d));
    rs2_d   = NR_BITS'(RB + int'(n_d) * K_STEPS + int'(k_d));
    rd_d    = NR_BITS'(RC + int'(m_d) * N_STEPS + int'(n_d));
    first_d = (m_d == '0) && (n_d == '0) && (k_d == '0);
    last_d  = (m_d == SM_W'(M_STEPS - 1)) && (n_d == SN_W'(N_STEPS - 1)) &&
              (k_d == SK_W'(K_STEPS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      tag_q   <= '0;
      fmt_s_q <= '0;
      fmt_d_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      k_q     <= k_d;
      tag_q   <= tag_d;
      fmt_s_q <= fmt_s_d;
      fmt_d_q <= fmt_d_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign io.in_ready   = in_ready;
  assign io.out_valid  = (state_q == ST_BUSY);
  assign io.out_tag    = tag_q;
  assign io.out_fmt_s  = fmt_s_q;
  assign io.out_fmt_d  = fmt_d_q;
  assign io.out_step_m = m_q;
  assign io.out_step_n = n_q;
  assign io.out_step_k = k_q;
  assign io.out_rs1    = rs1_q;
  assign io.out_rs2    = rs2_q;
  assign io.out_rs3    = rd_q;
  assign io.out_rd     = rd_q;
  assign io.out_first  = first_q;
  assign io.out_last   = last_q;

endmodule

// File: tb/tb_tcu_uop_sequencer.sv
module tb_tcu_uop_sequencer;
  import tcu_uop_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tcu_uop_sequencer_if #(.TAG_W(16), .NR_BITS(5), .SM_W(2), .SN_W(1), .SK_W(1)) if0 ();
  tcu_uop_sequencer_if #(.TAG_W(16), .NR_BITS(5), .SM_W(1), .SN_W(1), .SK_W(1)) if1 ();

  tcu_uop_sequencer #(.TAG_W(16)) dut0 (.clk(clk), .reset(reset), .io(if0));
  tcu_uop_sequencer #(.M_STEPS(1), .N_STEPS(1), .K_STEPS(1), .TAG_W(16))
    dut1 (.clk(clk), .reset(reset), .io(if1));

  typedef struct packed {
    int tag, fs, fd, m, n, k, rs1, rs2, rs3, rd;
    bit first, last;
  } obs_t;

  int   n_cmp = 0, n_err = 0;
  obs_t q0[$], q1[$], log0[$];
  obs_t o0, o1, prev0, prev1;
  bit   have_prev0, have_prev1;
  int   fires0;

  bit          rst_req, v0, v1, or0, or1, acc0, acc1;
  logic [15:0] tag0, tag1;
  logic [3:0]  fs0, fd0;

  function automatic string fmt(input obs_t o);
    return $sformatf("tag=%h fs=%0d fd=%0d m=%0d n=%0d k=%0d rs1=%0d rs2=%0d rs3=%0d rd=%0d first=%0b last=%0b",
                     o.tag, o.fs, o.fd, o.m, o.n, o.k, o.rs1, o.rs2, o.rs3, o.rd, o.first, o.last);
  endfunction

  task automatic check(input string nm, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {%s} required {%s}", nm, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  function automatic obs_t obs0();
    obs_t o;
    o.tag = int'(if0.out_tag);     o.fs = int'(if0.out_fmt_s); o.fd = int'(if0.out_fmt_d);
    o.m = int'(if0.out_step_m);    o.n = int'(if0.out_step_n); o.k = int'(if0.out_step_k);
    o.rs1 = int'(if0.out_rs1);     o.rs2 = int'(if0.out_rs2);
    o.rs3 = int'(if0.out_rs3);     o.rd = int'(if0.out_rd);
    o.first = if0.out_first;       o.last = if0.out_last;
    return o;
  endfunction

  function automatic obs_t obs1();
    obs_t o;
    o.tag = int'(if1.out_tag);     o.fs = int'(if1.out_fmt_s); o.fd = int'(if1.out_fmt_d);
    o.m = int'(if1.out_step_m);    o.n = int'(if1.out_step_n); o.k = int'(if1.out_step_k);
    o.rs1 = int'(if1.out_rs1);     o.rs2 = int'(if1.out_rs2);
    o.rs3 = int'(if1.out_rs3);     o.rd = int'(if1.out_rd);
    o.first = if1.out_first;       o.last = if1.out_last;
    return o;
  endfunction

  // Reference: micro-op number idx of an instruction, n fastest, k slowest.
  function automatic obs_t model_uop(input int ms, ns, ks, idx, tag, fs, fd);
    obs_t e;
    int   mod = 1 << TCU_NR_BITS;
    e.tag = tag; e.fs = fs; e.fd = fd;
    e.k   = idx / (ms * ns);
    e.m   = (idx % (ms * ns)) / ns;
    e.n   = idx % ns;
    e.rs1 = (TCU_RA + e.m * ks + e.k) % mod;
    e.rs2 = (TCU_RB + e.n * ks + e.k) % mod;
    e.rd  = (TCU_RC + e.m * ns + e.n) % mod;
    e.rs3 = e.rd;
    e.first = (idx == 0);
    e.last  = (idx == ms * ns * ks - 1);
    return e;
  endfunction

  // One clock of stimulus: drive at negedge, check in_ready at +1,
  // push expected micro-ops of an accepted instruction at +3.
  task automatic tick();
    @(negedge clk);
    reset         = rst_req;
    if0.in_valid  = v0;  if0.in_tag = tag0; if0.in_fmt_s = fs0; if0.in_fmt_d = fd0; if0.out_ready = or0;
    if1.in_valid  = v1;  if1.in_tag = tag1; if1.in_fmt_s = fs0; if1.in_fmt_d = fd0; if1.out_ready = or1;
    #1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!reset) begin
      check_int("in_ready0", int'(if0.in_ready), int'((q0.size() == 0) || (or0 && q0.size() == 1)));
      check_int("in_ready1", int'(if1.in_ready), int'((q1.size() == 0) || (or1 && q1.size() == 1)));
      acc0 = v0 && if0.in_ready;
      acc1 = v1 && if1.in_ready;
    end
    #2;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (acc0)
        for (int i = 0; i < TCU_UOPS; i++)
          q0.push_back(model_uop(TCU_M_STEPS, TCU_N_STEPS, TCU_K_STEPS, i, int'(tag0), int'(fs0), int'(fd0)));
      if (acc1)
        q1.push_back(model_uop(1, 1, 1, 0, int'(tag1), int'(fs0), int'(fd0)));
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    v0 = 1'b0; v1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    check_int("drain_left", q0.size() + q1.size(), 0);
  endtask

  // Monitors: pop and compare on every fire, check hold while stalled.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      check_int("out_valid0", int'(if0.out_valid), int'(q0.size() != 0));
      if (if0.out_valid) begin
        o0 = obs0();
        if (have_prev0) check("stall_hold0", o0, prev0);
        if (if0.out_ready) begin
          have_prev0 = 1'b0;
          if (q0.size() != 0) check("uop0", o0, q0.pop_front());
          log0.push_back(o0);
          fires0++;
        end else begin
          have_prev0 = 1'b1;
          prev0 = o0;
        end
      end
    end else have_prev0 = 1'b0;
  end

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      check_int("out_valid1", int'(if1.out_valid), int'(q1.size() != 0));
      if (if1.out_valid) begin
        o1 = obs1();
        if (have_prev1) check("stall_hold1", o1, prev1);
        if (if1.out_ready) begin
          have_prev1 = 1'b0;
          if (q1.size() != 0) check("uop1", o1, q1.pop_front());
        end else begin
          have_prev1 = 1'b1;
          prev1 = o1;
        end
      end
    end else have_prev1 = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t zero;
    int   c;
    zero = '0;
    reset = 1'b1; rst_req = 1'b1;
    v0 = 0; v1 = 0; or0 = 0; or1 = 0; tag0 = '0; tag1 = '0; fs0 = '0; fd0 = '0;
    fires0 = 0;
    repeat (3) tick();
    check("reset_fields0", obs0(), zero);
    check("reset_fields1", obs1(), zero);
    check_int("reset_valid0", int'(if0.out_valid), 0);
    check_int("reset_in_ready0", int'(if0.in_ready), 1);
    rst_req = 1'b0;
    tick();

    // Single instruction, full throughput.
    log0.delete();
    v0 = 1; tag0 = 16'h0; or0 = 1;
    tick();
    check_int("accept_idle", int'(acc0), 1);
    drain(40);
    check_int("count_single", log0.size(), 16);
    if (log0.size() == 16) begin
      check_int("uop0_rs2", log0[0].rs2, 28);
      check_int("uop0_rd", log0[0].rd, 10);
      check_int("uop0_first", int'(log0[0].first), 1);
      check_int("uop1_n", log0[1].n, 1);
      check_int("uop1_rs2", log0[1].rs2, 30);
      check_int("uop1_rd", log0[1].rd, 11);
      check_int("uop8_rs1", log0[8].rs1, 1);
      check_int("uop8_rs2", log0[8].rs2, 29);
      check_int("uop8_k", log0[8].k, 1);
      check_int("uop15_rs1", log0[15].rs1, 7);
      check_int("uop15_rs2", log0[15].rs2, 31);
      check_int("uop15_rd", log0[15].rd, 17);
      check_int("uop15_last", int'(log0[15].last), 1);
    end
    tick();
    check_int("idle_in_ready", int'(if0.in_ready), 1);

    // Random out_ready throttling.
    fires0 = 0;
    v0 = 1; tag0 = 16'($urandom); or0 = 1'($urandom);
    tick();
    v0 = 0;
    c = 0;
    while (q0.size() != 0 && c < 300) begin
      or0 = 1'($urandom);
      tick();
      c++;
    end
    check_int("throttle_fires", fires0, 16);
    drain(10);

    // Back-to-back with in_valid held.
    log0.delete();
    or0 = 1; v0 = 1; tag0 = 16'hA;
    tick();
    tag0 = 16'hB;
    c = 0;
    do begin tick(); c++; end while (!acc0 && c < 40);
    check_int("b2b_accept", int'(acc0), 1);
    drain(40);
    check_int("b2b_count", log0.size(), 32);
    if (log0.size() == 32) begin
      check_int("b2b_tag16", log0[16].tag, 16'hB);
      check_int("b2b_first16", int'(log0[16].first), 1);
      check_int("b2b_tag15", log0[15].tag, 16'hA);
    end

    // Reset after five fires.
    fires0 = 0;
    v0 = 1; tag0 = 16'h5; or0 = 1;
    tick();
    v0 = 0;
    c = 0;
    while (fires0 < 5 && c < 50) begin tick(); c++; end
    check_int("fires_before_reset", fires0, 5);
    rst_req = 1; tick();
    rst_req = 0; tick();
    check_int("post_reset_valid", int'(if0.out_valid), 0);
    check_int("post_reset_in_ready", int'(if0.in_ready), 1);
    log0.delete();
    v0 = 1; tag0 = 16'h6;
    tick();
    drain(40);
    check_int("restart_count", log0.size(), 16);
    if (log0.size() == 16) check("restart_uop0", log0[0], model_uop(4, 2, 2, 0, 16'h6, 0, 0));

    // Degenerate 1x1x1 instance streaming.
    v1 = 1; or1 = 1;
    repeat (10) begin tag1 = 16'($urandom); tick(); end
    repeat (30) begin
      tag1 = 16'($urandom); v1 = 1'($urandom); or1 = 1'($urandom);
      tick();
    end
    drain(10);

    // Format/tag pass-through, inputs changing mid-instruction.
    v0 = 1; tag0 = 16'h1234; fs0 = TCU_FMT_FP8; fd0 = TCU_FMT_FP16; or0 = 1;
    tick();
    v0 = 0;
    c = 0;
    while (q0.size() != 0 && c < 40) begin
      fs0 = 4'($urandom); fd0 = 4'($urandom); tag0 = 16'($urandom);
      tick();
      c++;
    end
    drain(10);

    // Random soak on both instances.
    repeat (400) begin
      v0 = ($urandom_range(0, 2) == 0); tag0 = 16'($urandom);
      fs0 = 4'($urandom); fd0 = 4'($urandom); or0 = ($urandom_range(0, 3) != 0);
      v1 = 1'($urandom); tag1 = 16'($urandom); or1 = 1'($urandom);
      tick();
    end
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tcu_uop_sequencer.md
Name: tcu_uop_sequencer

Overview:
Expands one accepted WMMA instruction into TCU_UOPS micro-ops. Each micro-op carries its (m,n,k) step and the resolved A/B/C register indices. Sits between the TCU dispatch slot and the tensor-core FEDP datapath: one instruction in, a stream of micro-ops out to the FEDP. Uses the tile/step geometry and register base addresses from the TCU package.

Parameters:
M_STEPS, 4, tile M steps (TCU_M_STEPS)
N_STEPS, 2, tile N steps (TCU_N_STEPS)
K_STEPS, 2, tile K steps (TCU_K_STEPS)
RA, 0, A register base
RB, 28, B register base
RC, 10, C/D register base
NR_BITS, 5, register index width
TAG_W, 16, opaque pass-through tag width (wid, uuid, tmask packed upstream)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  WMMA instruction valid
in_ready  out  1  instruction accepted when in_valid && in_ready
in_tag  in  TAG_W  pass-through tag
in_fmt_s  in  4  source format ID
in_fmt_d  in  4  destination format ID
out_valid  out  1  micro-op valid
out_ready  in  1  FEDP accepts micro-op
out_tag  out  TAG_W  latched tag
out_fmt_s  out  4  latched source format
out_fmt_d  out  4  latched destination format
out_step_m  out  max(1,clog2(M_STEPS))  m step
out_step_n  out  max(1,clog2(N_STEPS))  n step
out_step_k  out  max(1,clog2(K_STEPS))  k step
out_rs1  out  NR_BITS  A register
out_rs2  out  NR_BITS  B register
out_rs3  out  NR_BITS  C accumulator source
out_rd  out  NR_BITS  D destination
out_first  out  1  first micro-op of instruction
out_last  out  1  last micro-op of instruction

Behaviour:
- States: IDLE, BUSY. Reset -> IDLE; counters m,n,k = 0; latched tag/fmt = 0; out_valid = 0. All outputs derive from registered state, so all are 0 in reset.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). The combinational out_ready -> in_ready path is intentional.
- Accept: latch tag/fmt, zero counters, state BUSY. The first micro-op is valid the cycle after accept (latency 1).
- out_valid = (state==BUSY). All out_* fields hold stable while out_valid && !out_ready.
- Iteration order: n innermost, then m, then k outermost. Consecutive micro-ops therefore target distinct accumulators (no back-to-back RAW on rd).
- Advance on out fire: n++; on n wrap, n=0 and m++; on m wrap, m=0 and k++.
- out_last = (k==K_STEPS-1 && m==M_STEPS-1 && n==N_STEPS-1).
- out_first = all counters zero.
- On fire with out_last:
  - If in_valid: latch the new instruction, stay BUSY, counters 0 (zero-bubble back-to-back).
  - Else: go to IDLE.
- Register mapping, computed mod 2^NR_BITS, widths truncated:
  - rs1 = RA + m*K_STEPS + k
  - rs2 = RB + n*K_STEPS + k
  - rd = rs3 = RC + m*N_STEPS + n
- Degenerate M=N=K=1: a single micro-op with first=last=1. It also supports back-to-back accept.
- Reset mid-instruction: the in-flight instruction is dropped and no further micro-ops are emitted. Reset has priority over a simultaneous accept or fire.
- Total micro-ops per instruction = M_STEPS*N_STEPS*K_STEPS, exactly; none skipped or duplicated under any out_ready pattern.

Decomposition:
- Package (shared TCU package): step counts, RA/RB/RC, format IDs, TCU_UOPS.
- Add to the same package: a micro-op struct typedef {step_m, step_n, step_k, rs1, rs2, rs3, rd, first, last} plus derived step widths.
- Module: a single module; no sub-module. The step counter is a small nested counter inline.

Test Plan:
- Defaults, one instruction, out_ready=1 -> 16 micro-ops in consecutive cycles starting 1 cycle after accept.
  - uop0: (m0,n0,k0) rs1=0 rs2=28 rd=10 first=1.
  - uop1: (m0,n1,k0) rs1=0 rs2=30 rd=11.
  - uop8: (m0,n0,k1) rs1=1 rs2=29 rd=10.
  - uop15: (m3,n1,k1) rs1=7 rs2=31 rd=17 last=1.
  - Returns to IDLE and in_ready=1.
- Random out_ready throttling (~50%) -> fields stable while stalled; exactly 16 fires, same sequence as above; in_ready=0 throughout BUSY until the last fire.
- Two instructions with in_valid held (tags 0xA, 0xB) -> 32 micro-ops with no bubble; uop16 carries tag 0xB with first=1.
- Reset asserted after 5 fires -> next cycle out_valid=0 and in_ready=1; a new instruction restarts at (0,0,0).
- M=N=K=1 -> every instruction yields a single micro-op: rs1=RA, rs2=RB, rd=RC, first=last=1; 1 micro-op per cycle when streaming.
- fmt_s=3 (fp8), fmt_d=1 (fp16), tag 0x1234 -> all 16 micro-ops carry these values unchanged; in_fmt changing mid-instruction has no effect.
